control_pipe_sequencer: RTL and testbench
=========================================

// Module: control_pipe_sequencer
// PURPOSE
//  Consumer end of the control-unit bundle. Accepts decoded control (RegWEN, ALUSrc, ExtOp, dmemREN/WEN,
//  halt, branch, lui, tmpPC, RegDest, MemtoReg, ALUOP) at ID and carries it through EX/MEM/WB stage
//  registers. Handles: stall on data-memory wait, flush on taken branch, sticky halt with pipeline drain.
//  Sits between the control unit and the datapath stage latches; drives PC stall and the memory request.
// PARAMETERS
//  REG_AW   5   width of destination-register select carried to WB
// PORTS
//  CLK          in   1       clock, all state on rising edge
//  RST          in   1       synchronous, active-high reset
//  ihit         in   1       instruction fetch valid this cycle
//  dhit         in   1       data-memory access completes this cycle
//  id_valid     in   1       ID holds a real instruction
//  id_RegWEN, id_ALUSrc, id_ExtOp, id_dmemREN, id_dmemWEN, id_halt, id_branch, id_lui  in 1 each  decoded ctrl
//  id_tmpPC, id_RegDest, id_MemtoReg  in 2 each  decoded ctrl
//  id_ALUOP     in   4       aluop_t
//  id_wsel      in   REG_AW  destination register
//  ex_zero      in   1       ALU zero flag from EX
//  id_ready     out  1       ID bundle is accepted this cycle
//  ex_valid     out  1       EX holds a real instruction; plus ex_ALUSrc, ex_ExtOp, ex_lui (1), ex_ALUOP (4), ex_tmpPC (2)
//  mem_dmemREN  out  1       data read request
//  mem_dmemWEN  out  1       data write request
//  wb_RegWEN    out  1       register-file write strobe
//  wb_MemtoReg  out  2       WB result mux select
//  wb_wsel      out  REG_AW  WB destination register
//  pc_stall     out  1       hold PC / IF-ID
//  flush        out  1       squash IF-ID (taken branch)
//  halt         out  1       sticky halt
// BEHAVIOUR
//  - Stages EX, MEM, WB: each a valid bit plus registered fields. RST: all valids, fields, halt, and
//    halt_pending = 0. All outputs read 0 in the cycle after RST is sampled high.
//  - mem_busy = mem_v & (mem_REN|mem_WEN) & ~dhit; adv = ~mem_busy.
//  - taken = ex_v & ex_branch & ex_zero; flush = taken & adv.
//  - accept = id_valid & ihit & adv & ~halt_pending & ~flush; id_ready = adv & ~halt_pending & ~flush.
//  - On adv: EX <= accept ? ID bundle : bubble (flush forces bubble). MEM <= EX. WB <= MEM.
//  - On ~adv: EX, MEM hold. WB <= bubble, so each instruction writes the register file exactly once.
//  - Latency: an accepted bundle is in EX 1 cycle, MEM 2 cycles, and WB 3 cycles after acceptance
//    when no stall occurs.
//  - Request and write gating:
//    mem_dmemREN = mem_v & mem_REN; mem_dmemWEN = mem_v & mem_WEN.
//    A request stays high through the cycle dhit is asserted, then drops when MEM advances.
//    wb_RegWEN = wb_v & wb_RegWEN_r & ~halt.
//  - pc_stall = mem_busy | ~ihit | halt_pending | halt.
//  - halt_pending: set when a halt bundle is accepted; cleared only by RST.
//    All later ID bundles are refused (id_ready = 0).
//  - halt: set when WB holds a valid halt bundle. After that, all valids are cleared and the pipeline
//    is frozen until RST. The halt slot does not write the register file.
//  - A taken branch while MEM is busy: flush is deferred to the dhit cycle.
//    The branch holds in EX until then.
//  - id_valid with ~ihit: not accepted; a bubble enters EX.
//  - RST during an outstanding memory request: the request deasserts the next cycle and no WB write occurs.
// TESTING
//  1 RST=1 for 2 cycles with id_valid=1, ihit=1 -> all outputs 0, halt=0, id_ready=0 while RST=1.
//  2 addu (RegWEN=1, wsel=3, ALUOP=4'h2), ihit=1 -> ex_ALUOP=2 at t+1; wb_RegWEN=1, wb_wsel=3 at t+3 only.
//  3 lw (dmemREN=1, MemtoReg=1), dhit rises 3 cycles after MEM entry -> mem_dmemREN=1 for 4 cycles,
//    pc_stall=1 for 3, wb_RegWEN pulses once.
//  4 beq, ex_zero=1 -> flush=1 one cycle; next ID bundle never reaches MEM; ex_valid=0 the following cycle.
//  5 halt then addu -> id_ready=0 after halt accepted; halt=1 three cycles later; addu never writes;
//    halt held until RST.
//  6 sw waiting dhit with taken beq in EX -> flush=0 until the dhit cycle, then 1 for exactly one cycle.

Source files
------------

// File: rtl/control_pipe_sequencer_if.sv
// Control bundle between the control unit, the sequencer and the datapath stage latches.
interface control_pipe_sequencer_if #(
   parameter int REG_AW = 5
);
   // ID-side decoded control and handshake
   logic              ihit;
   logic              dhit;
   logic              id_valid;
   logic              id_RegWEN;
   logic              id_ALUSrc;
   logic              id_ExtOp;
   logic              id_dmemREN;
   logic              id_dmemWEN;
   logic              id_halt;
   logic              id_branch;
   logic              id_lui;
   logic [1:0]        id_tmpPC;
   logic [1:0]        id_RegDest;
   logic [1:0]        id_MemtoReg;
   logic [3:0]        id_ALUOP;
   logic [REG_AW-1:0] id_wsel;
   logic              ex_zero;
   // Sequencer outputs
   logic              id_ready;
   logic              ex_valid;
   logic              ex_ALUSrc;
   logic              ex_ExtOp;
   logic              ex_lui;
   logic [3:0]        ex_ALUOP;
   logic [1:0]        ex_tmpPC;
   logic [1:0]        ex_RegDest;
   logic              mem_dmemREN;
   logic              mem_dmemWEN;
   logic              wb_RegWEN;
   logic [1:0]        wb_MemtoReg;
   logic [REG_AW-1:0] wb_wsel;
   logic              pc_stall;
   logic              flush;
   logic              halt;

   modport master (
      output ihit, dhit, id_valid, id_RegWEN, id_ALUSrc, id_ExtOp, id_dmemREN, id_dmemWEN,
             id_halt, id_branch, id_lui, id_tmpPC, id_RegDest, id_MemtoReg, id_ALUOP, id_wsel,
             ex_zero,
      input  id_ready, ex_valid, ex_ALUSrc, ex_ExtOp, ex_lui, ex_ALUOP, ex_tmpPC, ex_RegDest,
             mem_dmemREN, mem_dmemWEN, wb_RegWEN, wb_MemtoReg, wb_wsel, pc_stall, flush, halt
   );

   modport slave (
      input  ihit, dhit, id_valid, id_RegWEN, id_ALUSrc, id_ExtOp, id_dmemREN, id_dmemWEN,
             id_halt, id_branch, id_lui, id_tmpPC, id_RegDest, id_MemtoReg, id_ALUOP, id_wsel,
             ex_zero,
      output id_ready, ex_valid, ex_ALUSrc, ex_ExtOp, ex_lui, ex_ALUOP, ex_tmpPC, ex_RegDest,
             mem_dmemREN, mem_dmemWEN, wb_RegWEN, wb_MemtoReg, wb_wsel, pc_stall, flush, halt
   );
endinterface

// File: rtl/control_pipe_sequencer.sv
// Carries decoded control from ID through EX/MEM/WB, stalling on data-memory wait,
// squashing on a taken branch and draining to a sticky halt.
module control_pipe_sequencer #(
   parameter int REG_AW = 5
) (
   input logic                       CLK,
   input logic                       RST,
   control_pipe_sequencer_if.slave   bus
);

   typedef struct packed {
      logic              regWen;
      logic              aluSrc;
      logic              extOp;
      logic              memRen;
      logic              memWen;
      logic              isHalt;
      logic              isBranch;
      logic              isLui;
      logic [1:0]        tmpPc;
      logic [1:0]        regDest;
      logic [1:0]        memToReg;
      logic [3:0]        aluOp;
      logic [REG_AW-1:0] wsel;
   } exCtrl_t;

   typedef struct packed {
      logic              regWen;
      logic              memRen;
      logic              memWen;
      logic              isHalt;
      logic [1:0]        memToReg;
      logic [REG_AW-1:0] wsel;
   } memCtrl_t;

   typedef struct packed {
      logic              regWen;
      logic              isHalt;
      logic [1:0]        memToReg;
      logic [REG_AW-1:0] wsel;
   } wbCtrl_t;

   logic     exV, memV, wbV;
   exCtrl_t  exR;
   memCtrl_t memR;
   wbCtrl_t  wbR;
   logic     haltPending, haltSticky;

   logic     memBusy, adv, taken, flushNow, haltNow, idOpen, accept;
   exCtrl_t  idBundle;

   // Stall/flush/accept decisions for this cycle
   always_comb begin
      memBusy  = memV & (memR.memRen | memR.memWen) & ~bus.dhit;
      adv      = ~memBusy;
      taken    = exV & exR.isBranch & bus.ex_zero;
      // a taken branch stuck behind a busy MEM waits in EX until the dhit cycle
      flushNow = taken & adv;
      // WB holding a valid halt raises halt in that very cycle so the slot never writes
      haltNow  = haltSticky | (wbV & wbR.isHalt);
      // reset gating keeps id_ready low while RST is held
      idOpen   = adv & ~haltPending & ~flushNow & ~RST;
      accept   = bus.id_valid & bus.ihit & idOpen;

      idBundle.regWen   = bus.id_RegWEN;
      idBundle.aluSrc   = bus.id_ALUSrc;
      idBundle.extOp    = bus.id_ExtOp;
      idBundle.memRen   = bus.id_dmemREN;
      idBundle.memWen   = bus.id_dmemWEN;
      idBundle.isHalt   = bus.id_halt;
      idBundle.isBranch = bus.id_branch;
      idBundle.isLui    = bus.id_lui;
      idBundle.tmpPc    = bus.id_tmpPC;
      idBundle.regDest  = bus.id_RegDest;
      idBundle.memToReg = bus.id_MemtoReg;
      idBundle.aluOp    = bus.id_ALUOP;
      idBundle.wsel     = bus.id_wsel;
   end

   // Stage registers: advance together, or hold EX/MEM and bubble WB while MEM waits
   always_ff @(posedge CLK) begin
      if (RST) begin
         exV         <= 1'b0;
         memV        <= 1'b0;
         wbV         <= 1'b0;
         exR         <= '0;
         memR        <= '0;
         wbR         <= '0;
         haltPending <= 1'b0;
         haltSticky  <= 1'b0;
      end else if (haltNow) begin
         // frozen until reset; nothing is left in flight
         exV        <= 1'b0;
         memV       <= 1'b0;
         wbV        <= 1'b0;
         exR        <= '0;
         memR       <= '0;
         wbR        <= '0;
         haltSticky <= 1'b1;
      end else begin
         if (adv) begin
            exV           <= accept;
            exR           <= accept ? idBundle : '0;
            memV          <= exV;
            memR.regWen   <= exR.regWen;
            memR.memRen   <= exR.memRen;
            memR.memWen   <= exR.memWen;
            memR.isHalt   <= exR.isHalt;
            memR.memToReg <= exR.memToReg;
            memR.wsel     <= exR.wsel;
            wbV           <= memV;
            wbR.regWen    <= memR.regWen;
            wbR.isHalt    <= memR.isHalt;
            wbR.memToReg  <= memR.memToReg;
            wbR.wsel      <= memR.wsel;
         end else begin
            // the stalled MEM instruction must not write twice
            wbV <= 1'b0;
            wbR <= '0;
         end
         if (accept && bus.id_halt) haltPending <= 1'b1;
      end
   end

   // Output drive
   always_comb begin
      bus.id_ready    = idOpen;
      bus.ex_valid    = exV;
      bus.ex_ALUSrc   = exR.aluSrc;
      bus.ex_ExtOp    = exR.extOp;
      bus.ex_lui      = exR.isLui;
      bus.ex_ALUOP    = exR.aluOp;
      bus.ex_tmpPC    = exR.tmpPc;
      bus.ex_RegDest  = exR.regDest;
      bus.mem_dmemREN = memV & memR.memRen;
      bus.mem_dmemWEN = memV & memR.memWen;
      bus.wb_RegWEN   = wbV & wbR.regWen & ~haltNow;
      bus.wb_MemtoReg = wbR.memToReg;
      bus.wb_wsel     = wbR.wsel;
      bus.pc_stall    = memBusy | ~bus.ihit | haltPending | haltNow;
      bus.flush       = flushNow;
      bus.halt        = haltNow;
   end

endmodule

// File: tb/tb_control_pipe_sequencer.sv
// Directed scenarios plus a randomized run against a stage-list reference model.
module tb_control_pipe_sequencer;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   control_pipe_sequencer_if #(.REG_AW(5)) bus ();

   control_pipe_sequencer #(.REG_AW(5)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model instruction: only the fields whose effects the bench observes
   typedef struct {
      bit       v;
      bit       regWen;
      bit       ren;
      bit       wen;
      bit       branch;
      bit [3:0] aluOp;
      bit [4:0] wsel;
   } mInstr_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearId();
      bus.id_valid    = 0; bus.id_RegWEN  = 0; bus.id_ALUSrc   = 0; bus.id_ExtOp = 0;
      bus.id_dmemREN  = 0; bus.id_dmemWEN = 0; bus.id_halt     = 0; bus.id_branch = 0;
      bus.id_lui      = 0; bus.id_tmpPC   = 0; bus.id_RegDest  = 0; bus.id_MemtoReg = 0;
      bus.id_ALUOP    = 0; bus.id_wsel    = 0;
   endtask

   task automatic doReset();
      clearId();
      bus.ihit = 1; bus.dhit = 0; bus.ex_zero = 0;
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      clearId();
      rst = 1; bus.ihit = 1; bus.dhit = 0; bus.ex_zero = 0; bus.id_valid = 1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %b want 0", bus.id_ready); end
         checks++;
         if ({bus.ex_valid, bus.mem_dmemREN, bus.mem_dmemWEN, bus.wb_RegWEN, bus.pc_stall, bus.flush, bus.halt} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0000000",
               {bus.ex_valid, bus.mem_dmemREN, bus.mem_dmemWEN, bus.wb_RegWEN, bus.pc_stall, bus.flush, bus.halt});
         end
         checks++;
         if ({bus.ex_ALUOP, bus.wb_wsel, bus.wb_MemtoReg} !== 11'b0) begin
            errors++; $display("FAIL reset_fields: got %h want 0", {bus.ex_ALUOP, bus.wb_wsel, bus.wb_MemtoReg});
         end
      end
      rst = 0;
      clearId();
   endtask

   task automatic test_addu();
      int writes;
      doReset();
      bus.id_valid = 1; bus.id_RegWEN = 1; bus.id_wsel = 5'd3; bus.id_ALUOP = 4'h2;
      #1;
      checks++;
      if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL addu_ready: got %b want 1", bus.id_ready); end
      tick();
      clearId();
      #1;
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_ALUOP !== 4'h2) begin
         errors++; $display("FAIL addu_ex: got v=%b op=%h want v=1 op=2", bus.ex_valid, bus.ex_ALUOP);
      end
      writes = 0;
      for (int k = 1; k <= 6; k++) begin
         if (k == 3) begin
            checks++;
            if (bus.wb_RegWEN !== 1'b1 || bus.wb_wsel !== 5'd3) begin
               errors++; $display("FAIL addu_wb: got en=%b wsel=%0d want en=1 wsel=3", bus.wb_RegWEN, bus.wb_wsel);
            end
         end
         if (bus.wb_RegWEN === 1'b1) writes++;
         tick();
      end
      checks++;
      if (writes != 1) begin errors++; $display("FAIL addu_write_count: got %0d want 1", writes); end
   endtask

   task automatic test_load_stall();
      int ren, stall, writes;
      doReset();
      bus.id_valid = 1; bus.id_dmemREN = 1; bus.id_MemtoReg = 2'd1; bus.id_RegWEN = 1; bus.id_wsel = 5'd5;
      ren = 0; stall = 0; writes = 0;
      for (int k = 0; k <= 9; k++) begin
         if (k == 1) clearId();
         bus.dhit = (k == 5);
         #1;
         if (bus.mem_dmemREN === 1'b1) ren++;
         if (bus.pc_stall === 1'b1) stall++;
         if (bus.wb_RegWEN === 1'b1) begin
            writes++;
            checks++;
            if (k != 6 || bus.wb_wsel !== 5'd5 || bus.wb_MemtoReg !== 2'd1) begin
               errors++; $display("FAIL lw_wb: got k=%0d wsel=%0d m2r=%0d want k=6 wsel=5 m2r=1", k, bus.wb_wsel, bus.wb_MemtoReg);
            end
         end
         tick();
      end
      bus.dhit = 0;
      checks++;
      if (ren != 4) begin errors++; $display("FAIL lw_ren_cycles: got %0d want 4", ren); end
      checks++;
      if (stall != 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 3", stall); end
      checks++;
      if (writes != 1) begin errors++; $display("FAIL lw_write_count: got %0d want 1", writes); end
   endtask

   task automatic test_reset_midreq();
      int bad;
      doReset();
      bus.id_valid = 1; bus.id_dmemREN = 1; bus.id_RegWEN = 1; bus.id_wsel = 5'd6;
      tick();
      clearId();
      tick();
      checks++;
      if (bus.mem_dmemREN !== 1'b1) begin errors++; $display("FAIL rstreq_pending: got %b want 1", bus.mem_dmemREN); end
      rst = 1;
      tick();
      rst = 0;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (bus.mem_dmemREN !== 1'b0 || bus.wb_RegWEN !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rstreq_after: got %0d active cycles want 0", bad); end
   endtask

   task automatic test_branch_flush();
      int leaks;
      doReset();
      bus.id_valid = 1; bus.id_branch = 1;
      tick();
      clearId();
      bus.id_valid = 1; bus.id_dmemWEN = 1; bus.id_RegWEN = 1; bus.id_wsel = 5'd7;
      bus.ex_zero = 1;
      #1;
      checks++;
      if (bus.flush !== 1'b1 || bus.id_ready !== 1'b0) begin
         errors++; $display("FAIL beq_flush: got flush=%b ready=%b want flush=1 ready=0", bus.flush, bus.id_ready);
      end
      tick();
      clearId();
      bus.ex_zero = 0;
      #1;
      checks++;
      if (bus.flush !== 1'b0 || bus.ex_valid !== 1'b0) begin
         errors++; $display("FAIL beq_after: got flush=%b exv=%b want 0 0", bus.flush, bus.ex_valid);
      end
      leaks = 0;
      for (int k = 0; k < 5; k++) begin
         if (bus.mem_dmemWEN === 1'b1 || bus.wb_RegWEN === 1'b1) leaks++;
         tick();
      end
      checks++;
      if (leaks != 0) begin errors++; $display("FAIL beq_squash: got %0d leak cycles want 0", leaks); end
   endtask

   task automatic test_stall_flush();
      int flushes;
      doReset();
      bus.id_valid = 1; bus.id_dmemWEN = 1;
      tick();
      clearId();
      bus.id_valid = 1; bus.id_branch = 1;
      tick();
      clearId();
      flushes = 0;
      bus.ex_zero = 1;
      for (int k = 2; k <= 7; k++) begin
         bus.dhit = (k == 5);
         #1;
         if (k == 2) begin
            checks++;
            if (bus.mem_dmemWEN !== 1'b1 || bus.pc_stall !== 1'b1) begin
               errors++; $display("FAIL swbeq_wait: got wen=%b stall=%b want 1 1", bus.mem_dmemWEN, bus.pc_stall);
            end
         end
         if (bus.flush === 1'b1) begin
            flushes++;
            checks++;
            if (k != 5) begin errors++; $display("FAIL swbeq_flush_cycle: got k=%0d want 5", k); end
         end
         if (k == 6) begin
            checks++;
            if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL swbeq_exv: got %b want 0", bus.ex_valid); end
         end
         tick();
      end
      bus.dhit = 0; bus.ex_zero = 0;
      checks++;
      if (flushes != 1) begin errors++; $display("FAIL swbeq_flush_count: got %0d want 1", flushes); end
   endtask

   task automatic test_halt();
      int writes, haltBad;
      doReset();
      bus.id_valid = 1; bus.id_halt = 1; bus.id_RegWEN = 1; bus.id_wsel = 5'd9;
      #1;
      checks++;
      if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL halt_accept: got %b want 1", bus.id_ready); end
      tick();
      clearId();
      bus.id_valid = 1; bus.id_RegWEN = 1; bus.id_wsel = 5'd4; bus.id_ALUOP = 4'h2;
      writes = 0; haltBad = 0;
      for (int k = 1; k <= 10; k++) begin
         #1;
         checks++;
         if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL halt_refuse: k=%0d got %b want 0", k, bus.id_ready); end
         if (bus.halt !== (k >= 3)) haltBad++;
         if (bus.wb_RegWEN === 1'b1) writes++;
         tick();
      end
      checks++;
      if (haltBad != 0) begin errors++; $display("FAIL halt_timing: got %0d wrong cycles want 0", haltBad); end
      checks++;
      if (writes != 0) begin errors++; $display("FAIL halt_writes: got %0d want 0", writes); end
      doReset();
      #1;
      checks++;
      if (bus.halt !== 1'b0 || bus.id_ready !== 1'b1) begin
         errors++; $display("FAIL halt_cleared: got halt=%b ready=%b want 0 1", bus.halt, bus.id_ready);
      end
   endtask

   task automatic test_random();
      mInstr_t mdl[3];
      mInstr_t nu;
      mInstr_t bubble;
      bit busy, eFlush, eReady, acc;
      int errBefore;
      doReset();
      bubble = '{default: 0};
      for (int s = 0; s < 3; s++) mdl[s] = bubble;
      for (int c = 0; c < 500; c++) begin
         bus.ihit        = ($urandom_range(0, 9) < 8);
         bus.dhit        = $urandom_range(0, 1);
         bus.ex_zero     = $urandom_range(0, 1);
         bus.id_valid    = $urandom_range(0, 1);
         bus.id_RegWEN   = $urandom_range(0, 1);
         bus.id_dmemREN  = ($urandom_range(0, 3) == 0);
         bus.id_dmemWEN  = ($urandom_range(0, 3) == 0);
         bus.id_branch   = ($urandom_range(0, 3) == 0);
         bus.id_ALUOP    = 4'($urandom_range(0, 15));
         bus.id_wsel     = 5'($urandom_range(0, 31));
         bus.id_MemtoReg = 2'($urandom_range(0, 3));
         #1;
         busy   = mdl[1].v && (mdl[1].ren || mdl[1].wen) && !bus.dhit;
         eFlush = mdl[0].v && mdl[0].branch && bus.ex_zero && !busy;
         eReady = !busy && !eFlush;
         acc    = bus.id_valid && bus.ihit && eReady;
         errBefore = errors;
         checks++;
         if (bus.id_ready !== eReady) begin errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, bus.id_ready, eReady); end
         checks++;
         if (bus.flush !== eFlush) begin errors++; $display("FAIL rnd_flush c=%0d: got %b want %b", c, bus.flush, eFlush); end
         checks++;
         if (bus.pc_stall !== (busy || !bus.ihit)) begin
            errors++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, bus.pc_stall, busy || !bus.ihit);
         end
         checks++;
         if (bus.mem_dmemREN !== (mdl[1].v && mdl[1].ren) || bus.mem_dmemWEN !== (mdl[1].v && mdl[1].wen)) begin
            errors++; $display("FAIL rnd_memreq c=%0d: got %b%b want %b%b", c, bus.mem_dmemREN, bus.mem_dmemWEN,
               mdl[1].v && mdl[1].ren, mdl[1].v && mdl[1].wen);
         end
         checks++;
         if (bus.wb_RegWEN !== (mdl[2].v && mdl[2].regWen)) begin
            errors++; $display("FAIL rnd_wb c=%0d: got %b want %b", c, bus.wb_RegWEN, mdl[2].v && mdl[2].regWen);
         end
         if (mdl[2].v && mdl[2].regWen) begin
            checks++;
            if (bus.wb_wsel !== mdl[2].wsel) begin errors++; $display("FAIL rnd_wsel c=%0d: got %0d want %0d", c, bus.wb_wsel, mdl[2].wsel); end
         end
         checks++;
         if (bus.ex_valid !== mdl[0].v || (mdl[0].v && bus.ex_ALUOP !== mdl[0].aluOp)) begin
            errors++; $display("FAIL rnd_ex c=%0d: got v=%b op=%h want v=%b op=%h", c, bus.ex_valid, bus.ex_ALUOP, mdl[0].v, mdl[0].aluOp);
         end
         if (errors - errBefore > 0 && errors > 20) break;
         nu.v = 1; nu.regWen = bus.id_RegWEN; nu.ren = bus.id_dmemREN; nu.wen = bus.id_dmemWEN;
         nu.branch = bus.id_branch; nu.aluOp = bus.id_ALUOP; nu.wsel = bus.id_wsel;
         if (!busy) begin
            mdl[2] = mdl[1];
            mdl[1] = mdl[0];
            mdl[0] = acc ? nu : bubble;
         end else begin
            mdl[2] = bubble;
         end
         tick();
      end
      clearId();
      bus.dhit = 0; bus.ex_zero = 0; bus.ihit = 1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1;
      bus.ihit = 1; bus.dhit = 0; bus.ex_zero = 0;
      clearId();
      test_reset();
      test_addu();
      test_load_stall();
      test_reset_midreq();
      test_branch_flush();
      test_stall_flush();
      test_random();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
